state_to_byte_serializer: RTL and testbench
===========================================

Name: state_to_byte_serializer

Overview:
Output-side counterpart to the byte-serial input assembler. Accepts a full 128-bit AES state (four 32-bit words) from the cipher core over a valid/ready handshake. Emits the state as 16 bytes on a byte-wide valid/ready stream in the same order the input side fills it: word0 first, MSB byte first. A one-block pending buffer plus the active shift register lets back-to-back blocks stream with no idle byte slot.

Parameters:
NUM_WORDS, 4, words per block (block width = NUM_WORDS*32)
BYTE_W, 8, output byte width; fixed at 8, no other value supported

Ports:
clk  in  1  clock; all logic on posedge
rst  in  1  synchronous, active-high reset
blk_in  in  NUM_WORDS*32  block; word0 = [127:96], word3 = [31:0]
blk_valid  in  1  blk_in valid
blk_ready  out  1  block can be accepted this cycle
byte_out  out  8  current output byte
byte_valid  out  1  byte_out valid
byte_ready  in  1  downstream consumes byte this cycle
byte_last  out  1  high with the 16th byte of a block
busy  out  1  active or pending block held

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. In the cycle after rst is sampled high: byte_out=0, byte_valid=0, byte_last=0, busy=0, idx=0, pending empty, state IDLE.
- blk_ready is combinational: = !rst && (!pend_full || byte_fire_last). It is 0 while rst is high.
- Accept = blk_valid && blk_ready. Byte fire = byte_valid && byte_ready. fire_last = fire with idx==15.
- Byte index idx is 4 bits and ranges 0..15.
  - byte_out = shreg[127-8*idx -: 8], registered so it is stable from the clock edge.
  - byte_last = (idx==15) && byte_valid.
- FSM states:
  - IDLE: shreg empty.
    - On accept, load shreg, set idx=0, go to SEND. byte_valid rises the next cycle (latency 1).
  - SEND: byte_valid=1.
    - Fire with idx<15: idx++.
    - fire_last with pending full: move pending into shreg, idx=0, stay in SEND. No bubble.
    - fire_last with pending empty and accept in the same cycle: load blk_in straight into shreg, idx=0, stay in SEND.
    - fire_last with pending empty and no accept: go to IDLE, byte_valid=0.
- Accept while in SEND:
  - Goes into the pending buffer, unless it is the direct-load case above.
  - If pending is full and fire_last happens in the same cycle: pending moves to shreg and the new block moves into pending, all in the same cycle.
- Backpressure: while byte_valid && !byte_ready, byte_out, byte_last and idx hold unchanged.
- byte_valid never drops mid-block.
- busy = (state==SEND) || pend_full.
- Reset mid-block: all held data is discarded. There is no partial-output flush and no error flag.
- blk_in is sampled only on accept. Changes on blk_in at any other time are ignored.

Decomposition:
- Shared package aes_io_pkg:
  - BYTES_PER_WORD=4
  - STATE_BYTES=16
  - IDX_W=4
  - typedef state_t for the 128-bit block
  - FSM state enum {IDLE, SEND}
- One natural sub-module: blk_hold_reg, the one-entry pending buffer with full flag, load and pop.
- Byte select, FSM and counter stay in the top module.

Test Plan:
- Single block 00112233_44556677_8899AABB_CCDDEEFF, byte_ready held 1:
  - bytes 00,11,…,FF on 16 consecutive cycles, the first one cycle after accept.
  - byte_last only on FF.
  - byte_valid=0 the following cycle; busy=0.
- Two blocks offered back-to-back, byte_ready=1:
  - second block accepted into pending and blk_ready goes 0.
  - 32 contiguous byte_valid cycles; byte_last at cycles 16 and 32.
- Random byte_ready toggling (~50%) over 3 blocks:
  - byte_out stable whenever valid && !ready.
  - output sequence exactly equals the 48 concatenated input bytes.
- Pending full, third block held on blk_valid:
  - blk_ready rises combinationally in the fire_last cycle of block 1.
  - third block captured that cycle; no byte lost or duplicated.
- rst asserted after byte 5 of a block with pending full:
  - next cycle byte_valid=0, busy=0, blk_ready=1.
  - a new block then starts from byte 0.
- byte_ready=0 for 10 cycles while holding byte 15:
  - byte_last and byte_out stay on byte 15 for all 10 cycles.
  - a single fire when byte_ready returns.

Source files
------------

// File: rtl/aes_io_pkg.sv
// -----------------------------------------------------------------------------
// aes_io_pkg
// Shared types and constants for the AES byte-serial I/O blocks.
//   STATE_BYTES : bytes in one 128-bit AES state
//   IDX_W       : width of the byte index within a state
//   LAST_IDX    : index of the final byte of a state
//   state_t     : one 128-bit AES state, word0 in the MSBs
//   fsm_state_t : serializer FSM states
//   byte_sel    : picks byte idx of a state, byte 0 = MSB byte
// -----------------------------------------------------------------------------
package aes_io_pkg;

    localparam int NUM_WORDS_DEF  = 4;
    localparam int BYTES_PER_WORD = 4;
    localparam int STATE_BYTES    = NUM_WORDS_DEF * BYTES_PER_WORD;
    localparam int IDX_W          = 4;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(STATE_BYTES - 1);

    typedef logic [STATE_BYTES*8-1:0] state_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } fsm_state_t;

    // Shifting left by 8*idx brings the wanted byte into the top byte lane.
    function automatic logic [7:0] byte_sel(input state_t s, input logic [IDX_W-1:0] idx);
        state_t w_shifted;
        w_shifted = s << {idx, 3'b000};
        return w_shifted[STATE_BYTES*8-1 -: 8];
    endfunction

endpackage

// File: rtl/blk_hold_reg.sv
// -----------------------------------------------------------------------------
// blk_hold_reg
// One-entry holding buffer for a complete AES state, with a full flag.
//   clk, rst  : clock, synchronous active-high reset (empties the buffer)
//   i_load    : capture i_data, buffer becomes full
//   i_pop     : release the held block, buffer becomes empty
//   i_data    : incoming block
//   o_data    : held block
//   o_full    : a block is held
// Load and pop in the same cycle replaces the held block and stays full.
// -----------------------------------------------------------------------------
module blk_hold_reg
    import aes_io_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   i_load,
    input  logic   i_pop,
    input  state_t i_data,
    output state_t o_data,
    output logic   o_full
);

    state_t r_data;
    logic   r_full;

    // Holding register and its occupancy flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= {STATE_BYTES*8{1'b0}};
            r_full <= 1'b0;
        end else if (i_load) begin
            r_data <= i_data;
            r_full <= 1'b1;
        end else if (i_pop) begin
            r_data <= r_data;
            r_full <= 1'b0;
        end else begin
            r_data <= r_data;
            r_full <= r_full;
        end
    end

    assign o_data = r_data;
    assign o_full = r_full;

endmodule

// File: rtl/state_to_byte_serializer.sv
// -----------------------------------------------------------------------------
// state_to_byte_serializer
// Takes a 128-bit AES state on a valid/ready handshake and emits it as 16
// bytes on a byte-wide valid/ready stream, word0 first, MSB byte first.
// A one-block pending buffer lets consecutive blocks stream without a gap.
//   clk, rst    : clock, synchronous active-high reset
//   blk_in      : block, word0 = [127:96], word3 = [31:0]
//   blk_valid   : blk_in valid
//   blk_ready   : block can be accepted this cycle (combinational)
//   byte_out    : current output byte (registered)
//   byte_valid  : byte_out valid
//   byte_ready  : downstream consumes the byte this cycle
//   byte_last   : marks the 16th byte of a block
//   busy        : a block is being sent or is pending
// -----------------------------------------------------------------------------
module state_to_byte_serializer
    import aes_io_pkg::*;
#(
    parameter int NUM_WORDS = 4,
    parameter int BYTE_W    = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_WORDS*32-1:0] blk_in,
    input  logic                   blk_valid,
    output logic                   blk_ready,
    output logic [BYTE_W-1:0]      byte_out,
    output logic                   byte_valid,
    input  logic                   byte_ready,
    output logic                   byte_last,
    output logic                   busy
);

    fsm_state_t       r_state;
    state_t           r_shreg;
    logic [IDX_W-1:0] r_idx;
    logic [BYTE_W-1:0] r_byte_out;
    logic             r_byte_valid;
    logic             r_byte_last;

    state_t           w_pend_data;
    logic             w_pend_full;
    logic             w_fire;
    logic             w_fire_last;
    logic             w_accept;
    logic             w_pend_load;
    logic             w_pend_pop;

    fsm_state_t       w_nxt_state;
    state_t           w_nxt_shreg;
    logic [IDX_W-1:0] w_nxt_idx;
    logic             w_nxt_valid;

    assign w_fire      = r_byte_valid && byte_ready;
    assign w_fire_last = w_fire && (r_idx == LAST_IDX);
    // The pending slot frees up in the very cycle the last byte leaves.
    assign blk_ready   = !rst && (!w_pend_full || w_fire_last);
    assign w_accept    = blk_valid && blk_ready;

    // An accepted block bypasses the pending slot when it can go straight into
    // the shift register: from IDLE, or on the last byte with nothing pending.
    assign w_pend_load = w_accept && (r_state == SEND) && !(w_fire_last && !w_pend_full);
    assign w_pend_pop  = w_fire_last && w_pend_full;

    blk_hold_reg u_pend (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_pend_load),
        .i_pop  (w_pend_pop),
        .i_data (blk_in),
        .o_data (w_pend_data),
        .o_full (w_pend_full)
    );

    // Next shift register, index, valid and FSM state.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_shreg = r_shreg;
        w_nxt_idx   = r_idx;
        w_nxt_valid = r_byte_valid;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_nxt_shreg = blk_in;
                    w_nxt_idx   = {IDX_W{1'b0}};
                    w_nxt_valid = 1'b1;
                    w_nxt_state = SEND;
                end else begin
                    w_nxt_valid = 1'b0;
                    w_nxt_state = IDLE;
                end
            end
            SEND: begin
                if (!w_fire) begin
                    w_nxt_state = SEND;
                end else if (r_idx != LAST_IDX) begin
                    w_nxt_idx = r_idx + IDX_W'(1);
                end else if (w_pend_full) begin
                    w_nxt_shreg = w_pend_data;
                    w_nxt_idx   = {IDX_W{1'b0}};
                end else if (w_accept) begin
                    w_nxt_shreg = blk_in;
                    w_nxt_idx   = {IDX_W{1'b0}};
                end else begin
                    w_nxt_valid = 1'b0;
                    w_nxt_state = IDLE;
                end
            end
            default: begin
                w_nxt_valid = 1'b0;
                w_nxt_state = IDLE;
            end
        endcase
    end

    // FSM and registered byte outputs; byte_out is selected from the next
    // shift register/index so it is stable straight from the clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_shreg      <= {STATE_BYTES*8{1'b0}};
            r_idx        <= {IDX_W{1'b0}};
            r_byte_out   <= {BYTE_W{1'b0}};
            r_byte_valid <= 1'b0;
            r_byte_last  <= 1'b0;
        end else begin
            r_state      <= w_nxt_state;
            r_shreg      <= w_nxt_shreg;
            r_idx        <= w_nxt_idx;
            r_byte_valid <= w_nxt_valid;
            r_byte_last  <= w_nxt_valid && (w_nxt_idx == LAST_IDX);
            if (w_nxt_valid) begin
                r_byte_out <= byte_sel(w_nxt_shreg, w_nxt_idx);
            end else begin
                r_byte_out <= {BYTE_W{1'b0}};
            end
        end
    end

    assign byte_out   = r_byte_out;
    assign byte_valid = r_byte_valid;
    assign byte_last  = r_byte_last;
    assign busy       = (r_state == SEND) || w_pend_full;

endmodule

// File: tb/tb_state_to_byte_serializer.sv
module tb_state_to_byte_serializer;

    logic         clk;
    logic         rst;
    logic [127:0] blk_in;
    logic         blk_valid;
    logic         blk_ready;
    logic [7:0]   byte_out;
    logic         byte_valid;
    logic         byte_ready;
    logic         byte_last;
    logic         busy;

    int n_vec  = 0;
    int n_miss = 0;

    localparam logic [127:0] B1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] B2 = 128'h0102030405060708090A0B0C0D0E0F10;
    localparam logic [127:0] B3 = 128'hF0E1D2C3B4A5968778695A4B3C2D1E0F;
    localparam logic [127:0] B4 = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
    localparam logic [127:0] B5 = 128'h55AA55AA_00FF00FF_12121212_80808080;
    localparam logic [127:0] B6 = 128'h3243F6A8_885A308D_313198A2_E0370734;

    state_to_byte_serializer #(.NUM_WORDS(4), .BYTE_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .blk_in     (blk_in),
        .blk_valid  (blk_valid),
        .blk_ready  (blk_ready),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .byte_last  (byte_last),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] bsel(input logic [127:0] b, input int k);
        return b[127-8*k -: 8];
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic expect_byte(input string tag, input logic [127:0] b, input int k);
        chk({tag, "_valid"}, byte_valid, 1'b1);
        chk({tag, "_byte"}, byte_out, bsel(b, k));
        chk({tag, "_last"}, byte_last, (k == 15));
    endtask

    task automatic expect_idle(input string tag);
        chk({tag, "_valid"}, byte_valid, 1'b0);
        chk({tag, "_last"}, byte_last, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
    endtask

    // Stream bytes k0..15 of a block with byte_ready held high.
    task automatic stream_block(input string tag, input logic [127:0] b, input int k0);
        for (int k = k0; k < 16; k++) begin
            expect_byte(tag, b, k);
            tick();
        end
    endtask

    logic [127:0] blks [0:2];
    logic [31:0]  lfsr;
    logic         stall_prev;
    logic [7:0]   out_prev;
    logic         last_prev;
    int           pos;
    int           nb;

    initial begin
        rst        = 1'b1;
        blk_in     = 128'h0;
        blk_valid  = 1'b0;
        byte_ready = 1'b1;
        @(negedge clk);
        tick();
        // Reset state
        #1;
        chk("rst_blk_ready", blk_ready, 1'b0);
        chk("rst_byte_out", byte_out, 8'h00);
        expect_idle("rst");
        rst = 1'b0;
        #1;
        chk("post_rst_blk_ready", blk_ready, 1'b1);

        // Single block, latency 1, blk_in changes after accept are ignored
        blk_in    = B1;
        blk_valid = 1'b1;
        tick();
        blk_valid = 1'b0;
        blk_in    = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF;
        stream_block("single", B1, 0);
        expect_idle("single_end");

        // Two blocks back to back
        blk_in    = B2;
        blk_valid = 1'b1;
        #1;
        chk("b2b_ready0", blk_ready, 1'b1);
        tick();
        blk_in = B3;
        #1;
        chk("b2b_ready1", blk_ready, 1'b1);
        expect_byte("b2b_a", B2, 0);
        tick();
        blk_valid = 1'b0;
        #1;
        chk("b2b_pend_ready", blk_ready, 1'b0);
        chk("b2b_busy", busy, 1'b1);
        stream_block("b2b_a", B2, 1);
        stream_block("b2b_b", B3, 0);
        expect_idle("b2b_end");

        // Pending full, third block waits on blk_valid
        blk_in    = B4;
        blk_valid = 1'b1;
        tick();
        blk_in = B5;
        expect_byte("p3_a", B4, 0);
        tick();
        blk_in = B6;
        for (int k = 1; k < 15; k++) begin
            #1;
            chk("p3_held_ready", blk_ready, 1'b0);
            expect_byte("p3_a", B4, k);
            tick();
        end
        #1;
        chk("p3_lastcyc_ready", blk_ready, 1'b1);
        expect_byte("p3_a", B4, 15);
        tick();
        blk_valid = 1'b0;
        #1;
        chk("p3_refill_ready", blk_ready, 1'b0);
        stream_block("p3_b", B5, 0);
        stream_block("p3_c", B6, 0);
        expect_idle("p3_end");

        // Random byte_ready over three blocks
        blks[0]    = B1;
        blks[1]    = B4;
        blks[2]    = B6;
        lfsr       = 32'h1234_5678;
        stall_prev = 1'b0;
        out_prev   = 8'h00;
        last_prev  = 1'b0;
        pos        = 0;
        nb         = 0;
        for (int c = 0; c < 400; c++) begin
            lfsr       = {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};
            byte_ready = lfsr[0];
            blk_valid  = (nb < 3);
            blk_in     = blks[(nb < 3) ? nb : 2];
            #1;
            if (stall_prev) begin
                chk("rnd_hold_byte", byte_out, out_prev);
                chk("rnd_hold_last", byte_last, last_prev);
                chk("rnd_hold_valid", byte_valid, 1'b1);
            end
            if (byte_valid && byte_ready && pos < 48) begin
                chk("rnd_byte", byte_out, bsel(blks[pos / 16], pos % 16));
                chk("rnd_last", byte_last, ((pos % 16) == 15));
                pos++;
            end
            stall_prev = byte_valid && !byte_ready;
            out_prev   = byte_out;
            last_prev  = byte_last;
            if (blk_valid && blk_ready) nb++;
            tick();
            if (pos == 48 && nb == 3) break;
        end
        blk_valid  = 1'b0;
        byte_ready = 1'b1;
        chk("rnd_count", pos, 48);
        expect_idle("rnd_end");

        // Reset mid-block with pending full
        blk_in    = B2;
        blk_valid = 1'b1;
        tick();
        blk_in = B3;
        expect_byte("mrst", B2, 0);
        tick();
        blk_valid = 1'b0;
        for (int k = 1; k < 5; k++) begin
            expect_byte("mrst", B2, k);
            tick();
        end
        chk("mrst_busy_before", busy, 1'b1);
        rst = 1'b1;
        #1;
        chk("mrst_ready_in_rst", blk_ready, 1'b0);
        tick();
        rst = 1'b0;
        #1;
        expect_idle("mrst_after");
        chk("mrst_byte_out", byte_out, 8'h00);
        chk("mrst_blk_ready", blk_ready, 1'b1);
        blk_in    = B5;
        blk_valid = 1'b1;
        tick();
        blk_valid = 1'b0;
        stream_block("mrst_new", B5, 0);
        expect_idle("mrst_end");

        // Backpressure on byte 15 for 10 cycles
        blk_in    = B4;
        blk_valid = 1'b1;
        tick();
        blk_valid = 1'b0;
        for (int k = 0; k < 15; k++) begin
            expect_byte("bp", B4, k);
            tick();
        end
        byte_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            expect_byte("bp_hold", B4, 15);
            chk("bp_hold_busy", busy, 1'b1);
            tick();
        end
        byte_ready = 1'b1;
        expect_byte("bp_release", B4, 15);
        tick();
        expect_idle("bp_end");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
